// File: rtl/ps2_device_tx.sv
// rtl/ps2_device_tx.sv - PS/2 device-side transmitter: byte FIFO feeding 11-bit keyboard-style frames
module ps2_device_tx #(
  parameter int HALF_DIV   = 8,
  parameter int IDLE_GAP   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       host_inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done,
  output logic       aborted
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (HALF_DIV > IDLE_GAP) ? HALF_DIV : IDLE_GAP;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(IDLE_GAP - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic [7:0]    head;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    frame_q;
  logic          in_frame;
  logic          phase_end;
  logic          stop_done;
  logic          abort_req;
  logic          do_start;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  // The head leaves only after its stop bit, so an aborted frame replays the same byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + AW'(1);
      if (stop_done) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(push) - (AW + 1)'(stop_done);
    end
  end

  assign in_frame  = (state == S_HIGH) || (state == S_LOW);
  assign phase_end = in_frame ? (cnt == HALF_LAST) : (cnt == GAP_LAST);
  assign stop_done = (state == S_LOW) && phase_end && (bit_idx == 4'd10);
  assign abort_req = in_frame && host_inhibit && (bit_idx <= 4'd9);
  // A queued byte may start straight out of the gap so back-to-back frames are spaced by exactly IDLE_GAP.
  assign do_start  = !empty && !host_inhibit &&
                     ((state == S_IDLE) || ((state == S_GAP) && phase_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      frame_q    <= '0;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      if (do_start) begin
        state    <= S_HIGH;
        cnt      <= '0;
        bit_idx  <= '0;
        frame_q  <= {1'b1, ~^head, head};
        ps2_clk  <= 1'b1;
        ps2_data <= 1'b0;
        busy     <= 1'b1;
      end else if (abort_req) begin
        state    <= S_GAP;
        cnt      <= '0;
        ps2_clk  <= 1'b1;
        ps2_data <= 1'b1;
        aborted  <= 1'b1;
      end else begin
        case (state)
          S_HIGH: begin
            if (phase_end) begin
              state   <= S_LOW;
              cnt     <= '0;
              ps2_clk <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_LOW: begin
            if (phase_end) begin
              cnt     <= '0;
              ps2_clk <= 1'b1;
              if (bit_idx == 4'd10) begin
                state      <= S_GAP;
                ps2_data   <= 1'b1;
                frame_done <= 1'b1;
              end else begin
                state    <= S_HIGH;
                bit_idx  <= bit_idx + 4'd1;
                ps2_data <= frame_q[0];
                frame_q  <= {1'b1, frame_q[9:1]};
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_GAP: begin
            if (phase_end) begin
              state <= S_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_IDLE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb/tb_ps2_device_tx.sv - directed bench for ps2_device_tx (HALF_DIV=4, IDLE_GAP=8, FIFO_DEPTH=4)
module tb_ps2_device_tx;

  localparam int HALF_DIV   = 4;
  localparam int IDLE_GAP   = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       host_inhibit = 1'b0;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       frame_done;
  logic       aborted;

  int errors = 0;
  int checks = 0;

  ps2_device_tx #(.HALF_DIV(HALF_DIV), .IDLE_GAP(IDLE_GAP), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .host_inhibit(host_inhibit), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy),
    .frame_done(frame_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Host-side receiver: shifts ps2_data on each ps2_clk fall, discards partial frames.
  logic        mon_prev = 1'b1;
  int          mon_n = 0;
  logic [10:0] mon_sh = '0;
  logic [7:0]  rx_q[$];
  logic [10:0] rx_raw[$];
  int          par_err = 0;

  always @(posedge clk) begin
    if (rst || aborted) begin
      mon_n = 0;
    end else if (mon_prev && !ps2_clk) begin
      mon_sh[mon_n] = ps2_data;
      mon_n++;
      if (mon_n == 11) begin
        rx_raw.push_back(mon_sh);
        rx_q.push_back(mon_sh[8:1]);
        if (mon_sh[0] !== 1'b0 || mon_sh[10] !== 1'b1 || mon_sh[9] !== ~^mon_sh[8:1]) par_err++;
        mon_n = 0;
      end
    end
    mon_prev = ps2_clk;
  end

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int t = 0; t < 1000; t++) begin
      if (busy === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_frame_done(output bit ok);
    ok = 0;
    for (int t = 0; t < 1000; t++) begin
      if (frame_done === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      if (busy === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({ps2_clk, ps2_data, busy, frame_done, aborted} !== 5'b11000) begin
      errors++; $display("FAIL reset_lines: clk,data,busy,done,abort=%b want 11000", {ps2_clk, ps2_data, busy, frame_done, aborted});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++; if ({ps2_clk, ps2_data, busy} !== 3'b110) begin
      errors++; $display("FAIL reset_idle: clk,data,busy=%b want 110", {ps2_clk, ps2_data, busy});
    end
  endtask

  task automatic test_single;
    logic [10:0] bits;
    int          nf;
    logic        prev;
    bit          early_done;
    rx_q.delete(); rx_raw.delete();
    in_data = 8'h1C; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || ps2_data !== 1'b1) begin
      errors++; $display("FAIL latency_n1: busy=%b data=%b want 0 1", busy, ps2_data);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ps2_data !== 1'b0 || ps2_clk !== 1'b1) begin
      errors++; $display("FAIL latency_n2: busy=%b data=%b clk=%b want 1 0 1", busy, ps2_data, ps2_clk);
    end
    bits = '0; nf = 0; prev = 1'b1; early_done = 0;
    for (int k = 1; k <= 88; k++) begin
      if (k > 1) @(negedge clk);
      if (frame_done === 1'b1) early_done = 1;
      if (prev && !ps2_clk) begin
        if (nf < 11) bits[nf] = ps2_data;
        nf++;
      end
      prev = ps2_clk;
    end
    checks++; if (nf !== 11) begin
      errors++; $display("FAIL single_fall_count: got %0d want 11", nf);
    end
    checks++; if (bits !== 11'h438) begin
      errors++; $display("FAIL single_bits: got %h want 438", bits);
    end
    checks++; if (early_done !== 1'b0) begin
      errors++; $display("FAIL single_early_done: frame_done seen within 88 frame cycles");
    end
    @(negedge clk);
    checks++; if ({frame_done, ps2_clk, ps2_data, busy} !== 4'b1111) begin
      errors++; $display("FAIL single_done: done,clk,data,busy=%b want 1111", {frame_done, ps2_clk, ps2_data, busy});
    end
    repeat (7) @(negedge clk);
    checks++; if (busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL single_gap_end: busy=%b done=%b want 1 0", busy, frame_done);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_drop: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int gap;
    rx_q.delete(); rx_raw.delete();
    in_data = 8'hF0; in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h1C;
    @(negedge clk);
    in_valid = 1'b0;
    wait_frame_done(ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL b2b_first_timeout: no frame_done, want one");
    end
    gap = 0;
    while (ps2_clk === 1'b1 && ps2_data === 1'b1 && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    checks++; if (gap !== 8 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: idle-high=%0d busy=%b want 8 1", gap, busy);
    end
    wait_frame_done(ok);
    if (ok) wait_idle(ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL b2b_second_timeout: second frame not finished");
    end
    checks++; if (rx_raw.size() !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d frames want 2", rx_raw.size());
    end else begin
      checks++; if (rx_raw[0] !== 11'h7E0) begin
        errors++; $display("FAIL b2b_frame0: got %h want 7e0", rx_raw[0]);
      end
      checks++; if (rx_raw[1] !== 11'h438) begin
        errors++; $display("FAIL b2b_frame1: got %h want 438", rx_raw[1]);
      end
    end
  endtask

  task automatic test_fifo_full;
    logic [7:0] d [5];
    logic       prev_ready;
    bit         ok;
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rx_q.delete(); rx_raw.delete();
    host_inhibit = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== (i < 4)) begin
        errors++; $display("FAIL full_ready_%0d: got %b want %b", i, in_ready, (i < 4));
      end
      in_data = d[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || ps2_clk !== 1'b1) begin
      errors++; $display("FAIL full_hold: ready=%b busy=%b clk=%b want 0 0 1", in_ready, busy, ps2_clk);
    end
    in_valid = 1'b0; host_inhibit = 1'b0;
    prev_ready = in_ready; ok = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin ok = 1; break; end
      prev_ready = in_ready;
    end
    checks++; if (!ok || prev_ready !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_pop_cycle: ok=%b ready_before=%b ready_after=%b want 1 0 1", ok, prev_ready, in_ready);
    end
    wait_idle(ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok || rx_q.size() !== 4) begin
      errors++; $display("FAIL full_count: ok=%b frames=%0d want 1 4", ok, rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rx_q[i] !== d[i]) begin
          errors++; $display("FAIL full_order_%0d: got %h want %h", i, rx_q[i], d[i]);
        end
      end
    end
  endtask

  task automatic test_abort;
    bit ok;
    bit bad;
    rx_q.delete(); rx_raw.delete();
    in_data = 8'hAA; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_start(ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL abort_start_timeout: frame never started");
    end
    repeat (33) @(negedge clk);
    host_inhibit = 1'b1;
    @(negedge clk);
    checks++; if ({aborted, ps2_clk, ps2_data, frame_done} !== 4'b1110) begin
      errors++; $display("FAIL abort_pulse: abort,clk,data,done=%b want 1110", {aborted, ps2_clk, ps2_data, frame_done});
    end
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || aborted !== 1'b0) bad = 1;
    end
    checks++; if (bad || busy !== 1'b0) begin
      errors++; $display("FAIL abort_hold: activity=%b busy=%b want 0 0", bad, busy);
    end
    host_inhibit = 1'b0;
    wait_frame_done(ok);
    if (ok) wait_idle(ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok || busy !== 1'b0 || rx_raw.size() !== 1) begin
      errors++; $display("FAIL abort_resend_count: ok=%b busy=%b frames=%0d want 1 0 1", ok, busy, rx_raw.size());
    end else begin
      checks++; if (rx_raw[0] !== 11'h754) begin
        errors++; $display("FAIL abort_resend_frame: got %h want 754", rx_raw[0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit bad;
    rx_q.delete(); rx_raw.delete();
    in_data = 8'h5A; in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    wait_start(ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL rstmid_start_timeout: frame never started");
    end
    repeat (45) @(negedge clk);
    checks++; if (ps2_clk !== 1'b0) begin
      errors++; $display("FAIL rstmid_phase: clk=%b want 0 (bit 5 low)", ps2_clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({ps2_clk, ps2_data, busy, in_ready, frame_done} !== 5'b11010) begin
      errors++; $display("FAIL rstmid_lines: clk,data,busy,ready,done=%b want 11010", {ps2_clk, ps2_data, busy, in_ready, frame_done});
    end
    rst = 1'b0;
    bad = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy !== 1'b0 || frame_done !== 1'b0 || ps2_clk !== 1'b1) bad = 1;
    end
    checks++; if (bad || rx_q.size() !== 0) begin
      errors++; $display("FAIL rstmid_flushed: activity=%b frames=%0d want 0 0", bad, rx_q.size());
    end
  endtask

  task automatic test_random;
    logic [7:0] sent[$];
    logic [7:0] b;
    bit         ok;
    int         t;
    rx_q.delete(); rx_raw.delete();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      in_data = b; in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (rx_q.size() >= 6) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) wait_idle(ok);
    checks++; if (!ok || rx_q.size() !== 6) begin
      errors++; $display("FAIL rand_count: ok=%b frames=%0d want 1 6", ok, rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (rx_q[i] !== sent[i]) begin
          errors++; $display("FAIL rand_byte_%0d: got %h want %h", i, rx_q[i], sent[i]);
        end
      end
    end
    checks++; if (par_err !== 0) begin
      errors++; $display("FAIL frame_format: %0d bad start/parity/stop frames, want 0", par_err);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_fifo_full;
    test_abort;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
